seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
Downstream consumer of the 3-bit sequence generator output. Samples the generator's Q bus, acquires phase alignment against a programmed cyclic reference sequence, then tracks it with a flywheel. Reports lock status, per-sample mismatch pulses and a saturating error count. Serves as the on-chip self-check for the sequence generator path.

Parameters:
SEQ_LEN, 6, number of entries in the reference cycle (2..8); entries must be unique.
SEQ, 18'b100_110_111_011_001_000, packed reference sequence; entry i = SEQ[3i+2:3i]. The default is the 3-bit Johnson sequence 000,001,011,111,110,100.
LOCK_N, 3, consecutive matching samples (including the first) needed to declare lock.
MISS_N, 2, consecutive mismatches in LOCKED that drop lock.
CNT_W, 8, err_count width.

Ports:
clk  in  1  rising-edge clock, shared with the generator.
clear  in  1  asynchronous active-high reset.
en  in  1  sample qualifier; q_in is consumed only on edges where en=1.
q_in  in  3  sequence generator Q.
locked  out  1  high while state is LOCKED (registered).
err  out  1  one-cycle pulse per mismatching sample while LOCKED.
phase  out  3  index of the entry expected at the next sample (0..SEQ_LEN-1).
err_count  out  CNT_W  saturating mismatch count.
state  out  2  HUNT=0, ACQ=1, LOCKED=2 (3 unused; decodes to HUNT).

Behaviour:
- clear=1: immediately, with no clock edge, force state=HUNT, phase=0, good_cnt=0, miss_cnt=0, err=0, locked=0, err_count=0. This applies at any time, including mid-lock.
- en=0: all state holds; err=0 on that edge.
- All decisions below apply on rising clk edges with en=1.
- HUNT:
  - q_in equals entry k → phase←(k+1) mod SEQ_LEN, good_cnt←1, state←ACQ. If LOCK_N=1, go straight to LOCKED.
  - No entry matches → stay in HUNT; err stays 0; err_count unchanged.
- ACQ:
  - q_in==SEQ[phase] → phase advances (wraps SEQ_LEN-1→0), good_cnt++. When good_cnt reaches LOCK_N → LOCKED, locked=1 from that edge.
  - Mismatch → HUNT, good_cnt←0, phase←0. No err and no count change; the sample is not re-searched.
- LOCKED:
  - Phase always advances (flywheel), whether the sample matches or not.
  - Match → miss_cnt←0.
  - Mismatch → err=1 for exactly that cycle, err_count+1 saturating at all-ones, miss_cnt++.
  - miss_cnt reaching MISS_N on this edge → state←HUNT, locked←0, phase←0, miss_cnt←0. err still pulses for that sample.
- Latency: with LOCK_N=3, locked rises on the 3rd consecutive matching en-edge. err asserts on the edge that samples the bad value.
- Wrap: phase arithmetic is mod SEQ_LEN, not mod 8.
- err_count clears only via clear.

Test Plan:
1. Reset, then drive 000,001,011,111,110,100,... with en=1 → state HUNT→ACQ→LOCKED; locked=1 after edge 3; phase=3 at lock; err never pulses; err_count=0.
2. Start mid-cycle at 111 → phase=4 after edge 1, locked after edge 3. Continue through the wrap 100→000 → phase goes 5→0 with no error.
3. When locked, substitute 101 for one expected 110 → err high one cycle; err_count=1; locked stays 1; the next correct value matches (flywheel).
4. When locked, two consecutive wrong values → err pulses twice; err_count=2; locked drops on the second edge; state=HUNT, phase=0; re-lock 3 edges after correct data resumes.
5. While locked, toggle en low for 4 cycles with garbage on q_in → no change to phase, err or err_count. Resume the correct sequence → no errors.
6. Assert clear asynchronously mid-lock, between clock edges → all outputs zero before the next edge. Separately, with CNT_W=2 and 5 isolated errors (MISS_N=2) → err_count saturates at 3.

Source files
------------

// File: rtl/seq_checker.sv
// seq_checker: self-check for the 3-bit sequence generator.
// It samples q_in and lines it up with a programmed cyclic reference sequence.
// Once lined up, it follows the sequence with a flywheel: the expected entry keeps
// advancing on every sample, even when a sample is wrong.
//
// Ports
//   clk        rising-edge clock, shared with the generator
//   clear      asynchronous active-high reset of all state and outputs
//   en         sample qualifier; q_in is consumed only on edges with en=1
//   q_in       generator Q bus
//   locked     high while the state is LOCKED (registered)
//   err        one-cycle pulse per mismatching sample while LOCKED
//   phase      index of the reference entry expected at the next sample
//   err_count  saturating count of mismatches seen while LOCKED
//   state      HUNT=0, ACQ=1, LOCKED=2 (3 is treated as HUNT)
module seq_checker #(
  parameter int                   SEQ_LEN = 6,
  parameter logic [3*SEQ_LEN-1:0] SEQ     = 18'b100_110_111_011_001_000,
  parameter int                   LOCK_N  = 3,
  parameter int                   MISS_N  = 2,
  parameter int                   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       q_in,
  output logic             locked,
  output logic             err,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(MISS_N + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [MW-1:0]    miss_q, miss_d, miss_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             locked_q;
  logic             hit;
  logic [2:0]       hit_idx;
  logic             match;

  function automatic logic [2:0] entry(input logic [2:0] idx);
    return SEQ[3*int'(idx) +: 3];
  endfunction

  // Phase wraps at SEQ_LEN, not at the natural 3-bit boundary.
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return (p == 3'(SEQ_LEN - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // HUNT search over every reference entry. The entries are unique, so at most one entry matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (q_in == entry(3'(k))) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  assign match    = (q_in == entry(phase_q));
  assign good_inc = good_q + GW'(1);
  assign miss_inc = miss_q + MW'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    good_d  = good_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (en) begin
      case (state_q)
        ACQ: begin
          if (match) begin
            phase_d = next_phase(phase_q);
            good_d  = good_inc;
            if (good_inc == GW'(LOCK_N)) state_d = LOCKED;
          end else begin
            // A rejected sample is not searched again. Hunting restarts on the next sample.
            state_d = HUNT;
            phase_d = 3'd0;
            good_d  = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            phase_d = next_phase(phase_q);
            miss_d  = '0;
          end else begin
            err_d = 1'b1;
            cnt_d = sat_inc(cnt_q);
            if (miss_inc == MW'(MISS_N)) begin
              state_d = HUNT;
              phase_d = 3'd0;
              miss_d  = '0;
              good_d  = '0;
            end else begin
              phase_d = next_phase(phase_q);
              miss_d  = miss_inc;
            end
          end
        end
        default: begin
          // HUNT, and the unused encoding 3, which falls back to HUNT.
          state_d = HUNT;
          if (hit) begin
            phase_d = next_phase(hit_idx);
            good_d  = GW'(1);
            state_d = (LOCK_N == 1) ? LOCKED : ACQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= HUNT;
      phase_q  <= 3'd0;
      good_q   <= '0;
      miss_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign phase     = phase_q;
  assign err_count = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic [2:0] q_in = 3'd0;

  logic       locked, err;
  logic [2:0] phase;
  logic [7:0] err_count;
  logic [1:0] state;

  logic       locked2, err2;
  logic [2:0] phase2;
  logic [1:0] err_count2;
  logic [1:0] state2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_checker dut (
    .clk(clk), .clear(clear), .en(en), .q_in(q_in),
    .locked(locked), .err(err), .phase(phase),
    .err_count(err_count), .state(state)
  );

  seq_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .clear(clear), .en(en), .q_in(q_in),
    .locked(locked2), .err(err2), .phase(phase2),
    .err_count(err_count2), .state(state2)
  );

  typedef struct {
    logic       en;
    logic [2:0] q;
    logic [1:0] st;
    logic [2:0] ph;
    logic       lk;
    logic       er;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  logic [2:0] ref_seq [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

  function automatic vec_t mk(input logic e, input logic [2:0] q, input logic [1:0] st,
                              input logic [2:0] ph, input logic lk, input logic er,
                              input logic [7:0] cnt);
    vec_t v;
    v.en = e; v.q = q; v.st = st; v.ph = ph; v.lk = lk; v.er = er; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [2:0] q);
    @(negedge clk);
    en   = e;
    q_in = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] ph,
                           input logic lk, input logic er, input logic [7:0] cnt);
    check({tag, " state"}, int'(state), int'(st));
    check({tag, " phase"}, int'(phase), int'(ph));
    check({tag, " locked"}, int'(locked), int'(lk));
    check({tag, " err"}, int'(err), int'(er));
    check({tag, " err_count"}, int'(err_count), int'(cnt));
    check({tag, " err_count2"}, int'(err_count2), (cnt > 8'd3) ? 3 : int'(cnt));
  endtask

  initial begin
    // Directed vectors: en, q_in, then the expected state, phase, locked, err, err_count after the edge.
    vecs.push_back(mk(1, 3'b010, 0, 0, 0, 0, 0)); // not in the sequence: stay in HUNT
    vecs.push_back(mk(1, 3'b101, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 1, 1, 0, 0, 0)); // entry 0 goes to ACQ
    vecs.push_back(mk(1, 3'b011, 0, 0, 0, 0, 0)); // ACQ mismatch goes back to HUNT, no search
    vecs.push_back(mk(1, 3'b000, 1, 1, 0, 0, 0)); // test 1
    vecs.push_back(mk(1, 3'b001, 1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 3'b011, 2, 3, 1, 0, 0)); // lock on the 3rd edge
    vecs.push_back(mk(1, 3'b111, 2, 4, 1, 0, 0));
    vecs.push_back(mk(1, 3'b110, 2, 5, 1, 0, 0));
    vecs.push_back(mk(1, 3'b100, 2, 0, 1, 0, 0)); // wrap 5 -> 0
    vecs.push_back(mk(1, 3'b000, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 3'b001, 2, 2, 1, 0, 0));
    vecs.push_back(mk(1, 3'b011, 2, 3, 1, 0, 0));
    vecs.push_back(mk(1, 3'b111, 2, 4, 1, 0, 0));
    vecs.push_back(mk(1, 3'b101, 2, 5, 1, 1, 1)); // test 3: single bad sample
    vecs.push_back(mk(1, 3'b100, 2, 0, 1, 0, 1)); // flywheel keeps the match
    vecs.push_back(mk(1, 3'b000, 2, 1, 1, 0, 1));
    vecs.push_back(mk(1, 3'b010, 2, 2, 1, 1, 2)); // test 4: first miss
    vecs.push_back(mk(1, 3'b010, 0, 0, 0, 1, 3)); // second miss drops lock
    vecs.push_back(mk(1, 3'b111, 1, 4, 0, 0, 3)); // test 2: start mid-cycle at 111
    vecs.push_back(mk(1, 3'b110, 1, 5, 0, 0, 3));
    vecs.push_back(mk(1, 3'b100, 2, 0, 1, 0, 3)); // relocked, wrapped
    vecs.push_back(mk(0, 3'b101, 2, 0, 1, 0, 3)); // test 5: en low with garbage
    vecs.push_back(mk(0, 3'b010, 2, 0, 1, 0, 3));
    vecs.push_back(mk(0, 3'b111, 2, 0, 1, 0, 3));
    vecs.push_back(mk(0, 3'b001, 2, 0, 1, 0, 3));
    vecs.push_back(mk(1, 3'b000, 2, 1, 1, 0, 3));
    vecs.push_back(mk(1, 3'b001, 2, 2, 1, 0, 3));

    // Reset state
    #2 clear = 1'b1;
    #1 check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].q);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ph, vecs[i].lk, vecs[i].er,
                vecs[i].cnt);
    end

    // Asynchronous clear between edges while locked
    @(negedge clk);
    en = 1'b0;
    #2 clear = 1'b1;
    #1 check_all("async_clear", 0, 0, 0, 0, 0);
    #1 clear = 1'b0;

    // Relock, then 5 isolated errors: err_count2 saturates at 3
    step(1, 3'b000);
    step(1, 3'b001);
    step(1, 3'b011);
    check_all("relock", 2, 3, 1, 0, 0);
    begin
      int ph_m = 3;
      int nerr = 0;
      for (int i = 0; i < 10; i++) begin
        logic       bad;
        logic [2:0] qv;
        bad = (i % 2 == 0);
        qv  = bad ? ~ref_seq[ph_m] : ref_seq[ph_m];
        if (bad) nerr++;
        ph_m = (ph_m + 1) % 6;
        step(1, qv);
        check_all($sformatf("sat%0d", i), 2, 3'(ph_m), 1, bad, 8'(nerr));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
